// File: rtl/l2_clreq_arb.sv
// l2_clreq_arb
//   Per-stream cache-line request arbiter between the L1 stream controller and
//   the L2 URAM. Round-robin arbitration over eligible streams feeds a single
//   registered L2 request slot. An outstanding-request credit counter and a
//   per-stream pending bit limit traffic. L2 responses are routed back to the
//   owning stream's one-hot handshake.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   i_req_v/r    : per-stream request handshake from/to the L1 controller
//   o_req_v/r    : L2 request handshake, o_req_sid carries the stream id
//   i_rsp_v/r    : L2 response handshake, i_rsp_sid carries the stream id
//   o_rsp_v/r    : per-stream one-hot response handshake to the L1 controller
//   o_err        : sticky protocol error (stray or out-of-range response)
//
// Optional feature (macro L2_CLREQ_ARB_STATS_EN)
//   o_stall_cnt  : cycles with an eligible stream but no capture possible
//   o_req_cnt    : accepted L2 requests
//   Both are saturating 32-bit registered counters.

module l2_clreq_arb #(
   parameter int nstrms    = 64,
   parameter int sid_width = $clog2(nstrms),
   parameter int max_outst = 8,
   parameter int cnt_width = $clog2(max_outst+1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [nstrms-1:0]    i_req_v,
   output logic [nstrms-1:0]    i_req_r,
   output logic                 o_req_v,
   input  logic                 o_req_r,
   output logic [sid_width-1:0] o_req_sid,
   input  logic                 i_rsp_v,
   output logic                 i_rsp_r,
   input  logic [sid_width-1:0] i_rsp_sid,
   output logic [nstrms-1:0]    o_rsp_v,
   input  logic [nstrms-1:0]    o_rsp_r,
   output logic                 o_err
`ifdef L2_CLREQ_ARB_STATS_EN
   ,
   output logic [31:0]          o_stall_cnt,
   output logic [31:0]          o_req_cnt
`endif
);

   localparam int SW1 = sid_width + 1;

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [sid_width-1:0]  r_sid;
   logic [sid_width-1:0]  r_rr;
   logic [nstrms-1:0]     r_pend;
   logic [cnt_width-1:0]  r_credit;
   logic                  r_err;

   logic [nstrms-1:0]     w_elig;
   logic                  w_gnt_v;
   logic [sid_width-1:0]  w_gnt;
   logic                  w_cap_en;
   logic                  w_cap;
   logic                  w_sid_ok;
   logic                  w_rsp_acc;
   logic                  w_rsp_clr;
   logic                  w_err_set;
   logic [nstrms-1:0]     w_clr_vec;

   assign o_req_v   = (r_state == ST_FULL);
   assign o_req_sid = r_sid;
   assign o_err     = r_err;

   assign w_elig   = i_req_v & ~r_pend;
   assign w_cap_en = (~o_req_v | o_req_r) & (r_credit < cnt_width'(max_outst)) & ~reset;
   assign w_cap    = w_cap_en & w_gnt_v;

   // Round-robin: first pass finds the lowest eligible index overall (the
   // wrap case); second pass overrides it with the lowest index >= rr.
   always_comb begin
      w_gnt_v = 1'b0;
      w_gnt   = '0;
      for (int i = nstrms-1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_gnt_v = 1'b1;
            w_gnt   = sid_width'(i);
         end
      end
      for (int i = nstrms-1; i >= 0; i--) begin
         if (w_elig[i] && i >= int'(r_rr)) w_gnt = sid_width'(i);
      end
   end

   always_comb begin
      i_req_r = '0;
      if (w_cap) i_req_r[w_gnt] = 1'b1;
   end

   // Out-of-range ids only exist when nstrms is not a power of two.
   assign w_sid_ok = ({1'b0, i_rsp_sid} < SW1'(nstrms));

   always_comb begin
      o_rsp_v = '0;
      i_rsp_r = 1'b0;
      if (!reset && w_sid_ok) begin
         i_rsp_r            = o_rsp_r[i_rsp_sid];
         o_rsp_v[i_rsp_sid] = i_rsp_v;
      end
   end

   assign w_rsp_acc = i_rsp_v & i_rsp_r;
   assign w_rsp_clr = w_rsp_acc & r_pend[i_rsp_sid];
   assign w_err_set = (w_rsp_acc & ~r_pend[i_rsp_sid]) | (i_rsp_v & ~w_sid_ok);
   assign w_clr_vec = o_rsp_v & {nstrms{w_rsp_clr}};

   // Output slot FSM
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cap)                            w_state_nxt = ST_FULL;
      else if (r_state == ST_FULL && o_req_r) w_state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sid    <= '0;
         r_rr     <= '0;
         r_pend   <= '0;
         r_credit <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_cap) begin
            r_sid <= w_gnt;
            r_rr  <= (w_gnt == sid_width'(nstrms-1)) ? '0 : w_gnt + 1'b1;
         end
         // Capture and clear never hit the same stream: pend blocks capture.
         r_pend <= (r_pend & ~w_clr_vec) | i_req_r;
         case ({w_cap, w_rsp_clr})
            2'b10:   r_credit <= r_credit + 1'b1;
            2'b01:   r_credit <= r_credit - 1'b1;
            default: r_credit <= r_credit;
         endcase
         if (w_err_set) r_err <= 1'b1;
      end
   end

`ifdef L2_CLREQ_ARB_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_req_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_req_cnt   <= '0;
      end else begin
         if ((|w_elig) && !w_cap_en && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (o_req_v && o_req_r && r_req_cnt != 32'hFFFF_FFFF)
            r_req_cnt <= r_req_cnt + 32'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_req_cnt   = r_req_cnt;
`endif

endmodule

// File: tb/tb_l2_clreq_arb.sv
module tb_l2_clreq_arb;

   localparam int N  = 12;
   localparam int MO = 4;
   localparam int SW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  i_req_v, i_req_r, o_rsp_v, o_rsp_r;
   logic          o_req_v, o_req_r, i_rsp_v, i_rsp_r, o_err;
   logic [SW-1:0] o_req_sid, i_rsp_sid;
`ifdef L2_CLREQ_ARB_STATS_EN
   logic [31:0]   o_stall_cnt, o_req_cnt;
`endif

   l2_clreq_arb #(.nstrms(N), .max_outst(MO)) dut (
      .clk(clk), .reset(reset),
      .i_req_v(i_req_v), .i_req_r(i_req_r),
      .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
      .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
      .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
      .o_err(o_err)
`ifdef L2_CLREQ_ARB_STATS_EN
      , .o_stall_cnt(o_stall_cnt), .o_req_cnt(o_req_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: set of pending streams, credit count, rr position,
   // and the contents of the single output slot.
   bit           m_valid = 1'b0;
   bit [N-1:0]   m_pend;
   int           m_credit, m_rr, m_sid;
   bit           m_full, m_err;
   longint       m_stall, m_reqc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_pend = '0; m_credit = 0; m_rr = 0; m_sid = 0;
      m_full = 1'b0; m_err = 1'b0; m_stall = 0; m_reqc = 0;
   endtask

   // Called once per cycle at the falling edge: compare, then advance.
   task automatic model_step();
      int         g;
      int         s;
      bit         cap_ok, sid_ok, any_elig, rr_e;
      logic [N-1:0] er, ev;
      if (!m_valid) begin
         if (reset === 1'b1) begin
            reset_model();
            m_valid = 1'b1;
         end
         return;
      end
      cap_ok   = !reset && (!m_full || o_req_r) && (m_credit < MO);
      g        = -1;
      any_elig = 1'b0;
      for (int k = 0; k < N; k++) begin
         s = (m_rr + k) % N;
         if (i_req_v[s] && !m_pend[s]) begin
            any_elig = 1'b1;
            if (g < 0) g = s;
         end
      end
      er = '0;
      if (cap_ok && g >= 0) er[g] = 1'b1;
      sid_ok = int'(i_rsp_sid) < N;
      ev     = '0;
      rr_e   = 1'b0;
      if (!reset && sid_ok) begin
         rr_e = o_rsp_r[i_rsp_sid];
         if (i_rsp_v) ev[i_rsp_sid] = 1'b1;
      end
      chk("m_o_req_v",   32'(o_req_v),   32'(m_full));
      chk("m_o_req_sid", 32'(o_req_sid), m_sid);
      chk("m_o_err",     32'(o_err),     32'(m_err));
      chk("m_i_req_r",   32'(i_req_r),   32'(er));
      chk("m_o_rsp_v",   32'(o_rsp_v),   32'(ev));
      chk("m_i_rsp_r",   32'(i_rsp_r),   32'(rr_e));
`ifdef L2_CLREQ_ARB_STATS_EN
      chk("m_stall_cnt", o_stall_cnt, 32'(m_stall));
      chk("m_req_cnt",   o_req_cnt,   32'(m_reqc));
`endif
      if (reset) begin
         reset_model();
      end else begin
         if (m_full && o_req_r && m_reqc < 64'hFFFF_FFFF) m_reqc++;
         if (any_elig && !cap_ok && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (i_rsp_v && !sid_ok) m_err = 1'b1;
         if (i_rsp_v && rr_e) begin
            if (m_pend[i_rsp_sid]) begin
               m_pend[i_rsp_sid] = 1'b0;
               m_credit--;
            end else begin
               m_err = 1'b1;
            end
         end
         if (er != '0) begin
            m_full = 1'b1; m_sid = g; m_pend[g] = 1'b1;
            m_rr = (g + 1) % N; m_credit++;
         end else if (m_full && o_req_r) begin
            m_full = 1'b0;
         end
      end
   endtask

   int            seq[$];
   logic [N-1:0]  cl_exp [6];

   initial begin
      reset = 1'b1; i_req_v = '0; o_req_r = 1'b0;
      i_rsp_v = 1'b0; i_rsp_sid = '0; o_rsp_r = '1;
      cl_exp = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h000, 12'h000};

      // Reset state; requests present during reset are not accepted
      tick(); i_req_v = '1; tick();
      settle(); chk("rst_i_req_r", 32'(i_req_r), 0);
      chk("rst_o_req_v", 32'(o_req_v), 0);
      chk("rst_o_err",   32'(o_err),   0);
      chk("rst_sid",     32'(o_req_sid), 0);

      // Single request on stream 5
      reset = 1'b0; i_req_v = 12'h020; o_req_r = 1'b1;
      settle(); chk("single_gnt", 32'(i_req_r), 'h020);
      tick(); i_req_v = '0;
      chk("single_v", 32'(o_req_v), 1); chk("single_sid", 32'(o_req_sid), 5);
      i_rsp_v = 1'b1; i_rsp_sid = 4'd5;
      settle(); chk("single_rspv", 32'(o_rsp_v), 'h020); chk("single_rspr", 32'(i_rsp_r), 1);
      tick(); i_rsp_v = 1'b0;
      chk("single_drain", 32'(o_req_v), 0);
      tick();

      // Round robin over streams 0,3,7 with immediate responses
      do_reset();
      i_req_v = 12'h089; o_req_r = 1'b1;
      repeat (7) begin
         if (o_req_v) begin
            seq.push_back(int'(o_req_sid));
            i_rsp_v = 1'b1; i_rsp_sid = o_req_sid;
         end else begin
            i_rsp_v = 1'b0;
         end
         tick();
      end
      i_rsp_v = 1'b0; i_req_v = '0;
      chk("rr_count", seq.size(), 6);
      if (seq.size() == 6) begin
         chk("rr_0", seq[0], 0); chk("rr_1", seq[1], 3); chk("rr_2", seq[2], 7);
         chk("rr_3", seq[3], 0); chk("rr_4", seq[4], 3); chk("rr_5", seq[5], 7);
      end
      tick();

      // Credit limit: all streams request, no responses
      do_reset();
      i_req_v = '1; o_req_r = 1'b1;
      for (int k = 0; k < 6; k++) begin
         settle(); chk($sformatf("credit_gnt%0d", k), 32'(i_req_r), 32'(cl_exp[k]));
         tick();
      end
      i_rsp_v = 1'b1; i_rsp_sid = 4'd0;
      settle(); chk("credit_same_cyc", 32'(i_req_r), 0);
      tick(); i_rsp_v = 1'b0;
      settle(); chk("credit_next", 32'(i_req_r), 'h010);
      tick();

      // Backpressure on stream 4 while stream 6 waits
      do_reset();
      i_req_v = 12'h010; o_req_r = 1'b0;
      tick();
      i_req_v = 12'h050;
      repeat (10) begin
         settle();
         chk("bp_sid", 32'(o_req_sid), 4); chk("bp_rdy", 32'(i_req_r), 0);
         tick();
      end
      o_req_r = 1'b1;
      settle(); chk("bp_release", 32'(i_req_r), 'h040);
      tick(); i_req_v = '0;
      chk("bp_next_sid", 32'(o_req_sid), 6);

      // Stray response for stream 9
      i_rsp_v = 1'b1; i_rsp_sid = 4'd9;
      settle(); chk("stray_rspr", 32'(i_rsp_r), 1); chk("stray_rspv", 32'(o_rsp_v), 'h200);
      tick(); i_rsp_v = 1'b0;
      chk("stray_err", 32'(o_err), 1);
      repeat (3) tick();
      chk("stray_sticky", 32'(o_err), 1);
      i_rsp_v = 1'b1; i_rsp_sid = 4'd4;
      tick(); i_rsp_v = 1'b0;
      tick();

      // Out-of-range response id
      do_reset();
      i_rsp_v = 1'b1; i_rsp_sid = 4'd13;
      settle(); chk("oor_rspv", 32'(o_rsp_v), 0); chk("oor_rspr", 32'(i_rsp_r), 0);
      tick(); i_rsp_v = 1'b0;
      chk("oor_err", 32'(o_err), 1);

      // Mid-operation reset with three outstanding
      i_req_v = '1; o_req_r = 1'b1;
      repeat (3) tick();
      o_req_r = 1'b0;
      settle(); chk("mid_full", 32'(o_req_v), 1);
      reset = 1'b1;
      tick();
      chk("mid_v", 32'(o_req_v), 0); chk("mid_err", 32'(o_err), 0); chk("mid_sid", 32'(o_req_sid), 0);
      reset = 1'b0; o_req_r = 1'b1;
      settle(); chk("mid_first", 32'(i_req_r), 'h001);
      repeat (6) tick();
      i_req_v = '0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; i_req_v = '0; i_rsp_v = 1'b0; o_req_r = 1'b0;
      tick();
      reset = 1'b0;
   endtask

endmodule
